// File: rtl/pkmc_sdram_refresh_ctrl.sv
// Periodic SDRAM auto-refresh scheduler: interval timer, saturating pending count, PRE/AREF burst FSM.
// Optional PKMC_REFRESH_URGENT_EN adds the urgent output and batches requests until two refreshes are owed.
module pkmc_sdram_refresh_ctrl #(
  parameter int CLK_PER_REF = 390,
  parameter int T_RP        = 2,
  parameter int T_RFC       = 7,
  parameter int MAX_PEND    = 8,
  parameter int PEND_W      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              refresh_ack,
  output logic              refresh_req,
  output logic              sdram_cs_n,
  output logic [2:0]        sdram_cmd,
  output logic              sdram_a10,
  output logic              busy,
  output logic [PEND_W-1:0] pend_cnt,
  output logic              ovf
`ifdef PKMC_REFRESH_URGENT_EN
  ,
  output logic              urgent
`endif
);

  localparam logic [2:0] CMD_NOP  = 3'b111;
  localparam logic [2:0] CMD_PRE  = 3'b010;
  localparam logic [2:0] CMD_AREF = 3'b001;

  localparam int CNT_W   = (CLK_PER_REF > 1) ? $clog2(CLK_PER_REF) : 1;
  localparam int TMR_MAX = (T_RFC > T_RP) ? T_RFC : T_RP;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_PRE,
    S_WAIT_RP,
    S_AREF,
    S_WAIT_RFC,
    S_DONE
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   int_cnt;
  logic [TMR_W-1:0]   tmr;
  logic               tick;
  logic               aref_fire;
  logic               pend_max;
  logic               start_ok;
  logic [PEND_W-1:0]  pend_nxt;

  assign tick      = enable && (int_cnt == CNT_W'(CLK_PER_REF - 1));
  assign aref_fire = (state == S_AREF);
  assign pend_max  = (pend_cnt == PEND_W'(MAX_PEND));

  always_comb begin
    pend_nxt = pend_cnt;
    if (tick && !aref_fire && !pend_max)
      pend_nxt = pend_cnt + PEND_W'(1);
    else if (aref_fire && !tick && (pend_cnt != '0))
      pend_nxt = pend_cnt - PEND_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_cnt <= '0;
    end else if (enable) begin
      int_cnt <= tick ? '0 : int_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      pend_cnt <= pend_nxt;
      if (tick && !aref_fire && pend_max)
        ovf <= 1'b1;
    end
  end

`ifdef PKMC_REFRESH_URGENT_EN
  // urgent follows pend_nxt so it is aligned with the registered pend_cnt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      urgent <= 1'b0;
    else
      urgent <= (pend_nxt >= PEND_W'(MAX_PEND - 1));
  end
  assign start_ok = (pend_cnt != '0) && ((pend_cnt > PEND_W'(1)) || urgent);
`else
  assign start_ok = (pend_cnt != '0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      tmr         <= '0;
      refresh_req <= 1'b0;
      busy        <= 1'b0;
      sdram_cs_n  <= 1'b1;
      sdram_cmd   <= CMD_NOP;
      sdram_a10   <= 1'b0;
    end else begin
      sdram_cs_n <= 1'b1;
      sdram_cmd  <= CMD_NOP;
      sdram_a10  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            state       <= S_REQ;
            refresh_req <= 1'b1;
            busy        <= 1'b1;
          end
        end
        S_REQ: begin
          if (refresh_ack) begin
            state      <= S_PRE;
            sdram_cs_n <= 1'b0;
            sdram_cmd  <= CMD_PRE;
            sdram_a10  <= 1'b1;
          end
        end
        S_PRE: begin
          if (T_RP == 1) begin
            state      <= S_AREF;
            sdram_cs_n <= 1'b0;
            sdram_cmd  <= CMD_AREF;
          end else begin
            state <= S_WAIT_RP;
            tmr   <= TMR_W'(T_RP - 2);
          end
        end
        S_WAIT_RP: begin
          if (tmr == '0) begin
            state      <= S_AREF;
            sdram_cs_n <= 1'b0;
            sdram_cmd  <= CMD_AREF;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        S_AREF: begin
          // with no WAIT_RFC cycles the continue decision must see this AREF's decrement
          if (T_RFC == 1) begin
            if (pend_nxt != '0) begin
              state      <= S_AREF;
              sdram_cs_n <= 1'b0;
              sdram_cmd  <= CMD_AREF;
            end else begin
              state       <= S_DONE;
              refresh_req <= 1'b0;
            end
          end else begin
            state <= S_WAIT_RFC;
            tmr   <= TMR_W'(T_RFC - 2);
          end
        end
        S_WAIT_RFC: begin
          if (tmr != '0) begin
            tmr <= tmr - TMR_W'(1);
          end else if (pend_cnt != '0) begin
            state      <= S_AREF;
            sdram_cs_n <= 1'b0;
            sdram_cmd  <= CMD_AREF;
          end else begin
            state       <= S_DONE;
            refresh_req <= 1'b0;
          end
        end
        S_DONE: begin
          if (!refresh_ack) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state       <= S_IDLE;
          refresh_req <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule
